// File: rtl/pipe_in_pack_pkg.sv
// Shared constants for the Pipe In packing FIFO: word widths, default geometry
// and the occupancy-counter width helper.
package pipe_in_pack_pkg;
    localparam int WORD_W           = 32;
    localparam int PACK_W           = 64;
    localparam int DEF_DEPTH_LOG2   = 9;
    localparam int DEF_READY_THRESH = 128;

    // One extra bit so that count can represent a completely full FIFO.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/pipe_in_pack_fifo_if.sv
// Handshake bundle between the host Pipe In endpoint / checker (master)
// and the packing FIFO (slave).
interface pipe_in_pack_fifo_if;
    import pipe_in_pack_pkg::*;

    logic              flush;
    logic              ep_write;
    logic [WORD_W-1:0] ep_dataout;
    logic              ep_ready;
    logic              rd_en;
    logic [PACK_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;

    modport master (
        output flush, ep_write, ep_dataout, rd_en,
        input  ep_ready, rd_data, rd_valid, empty, full
    );

    modport slave (
        input  flush, ep_write, ep_dataout, rd_en,
        output ep_ready, rd_data, rd_valid, empty, full
    );
endinterface

// File: rtl/pipe_in_pack_ram.sv
// Simple dual-port RAM with a registered read port; the array has no reset
// so it maps onto block RAM.
module pipe_in_pack_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Read-before-write on an address collision: a pop from a full FIFO sees
    // the old entry while the simultaneous push overwrites that slot.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        if (re)
            rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/pipe_in_pack_fifo.sv
// Packs pairs of 32-bit Pipe In words into 64-bit FIFO entries for the checker.
// Optional PIPE_IN_PACK_STATUS_EN adds the level and overflow status ports.
module pipe_in_pack_fifo
    import pipe_in_pack_pkg::*;
#(
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int READY_THRESH = DEF_READY_THRESH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pipe_in_pack_fifo_if.slave    bus
`ifdef PIPE_IN_PACK_STATUS_EN
    ,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(READY_THRESH);

    logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  half_v_reg;
    logic [WORD_W-1:0]     half_q_reg;
    logic                  rd_valid_reg;
    logic                  ep_ready_reg;
    logic [PACK_W-1:0]     hold_reg;
    logic [PACK_W-1:0]     ram_q;
    logic                  full_w, pair_done, push, pop, drop;

    assign full_w = (count_reg == DEPTH_C);

    always_comb begin
        pair_done  = bus.ep_write && half_v_reg;
        pop        = bus.rd_en && (count_reg != '0) && !bus.flush;
        push       = pair_done && (!full_w || pop) && !bus.flush;
        drop       = pair_done && full_w && !pop && !bus.flush;
        count_next = count_reg;
        if (bus.flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (pop && !push)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            half_v_reg   <= 1'b0;
            half_q_reg   <= '0;
            rd_valid_reg <= 1'b0;
            ep_ready_reg <= 1'b1;
            hold_reg     <= '0;
        end else begin
            count_reg    <= count_next;
            rd_valid_reg <= pop;
            ep_ready_reg <= (DEPTH_C - count_next) >= THRESH_C;
            if (rd_valid_reg)
                hold_reg <= ram_q;
            if (bus.flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                half_v_reg <= 1'b0;
            end else begin
                // half_v toggles even when the pair is dropped, keeping alignment.
                if (bus.ep_write) begin
                    half_v_reg <= !half_v_reg;
                    if (!half_v_reg)
                        half_q_reg <= bus.ep_dataout;
                end
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    pipe_in_pack_ram #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (PACK_W)
    ) u_ram (
        .clk     (clk),
        .we      (push),
        .wr_addr (wr_ptr_reg),
        .wr_data ({bus.ep_dataout, half_q_reg}),
        .re      (pop),
        .rd_addr (rd_ptr_reg),
        .rd_data (ram_q)
    );

    // The RAM output register has no reset; hold_reg supplies the reset value
    // and the last-read value whenever rd_valid is low.
    assign bus.rd_data  = rd_valid_reg ? ram_q : hold_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.empty    = (count_reg == '0);
    assign bus.full     = full_w;
    assign bus.ep_ready = ep_ready_reg;

`ifdef PIPE_IN_PACK_STATUS_EN
    logic overflow_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow_reg <= 1'b0;
        else if (bus.flush)
            overflow_reg <= 1'b0;
        else if (drop)
            overflow_reg <= 1'b1;
    end

    assign level    = count_reg;
    assign overflow = overflow_reg;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif
endmodule
